conc_stim_player: RTL and testbench
===================================

Name: conc_stim_player

Overview:
Synthesizable, parametrised stimulus replay engine for concolic test harnesses.
- Stores a preloaded vector table and drives `datai`/`obs` into a DUT once per clock.
- Supports one-shot or looping playback, a per-entry hold count, start/stop control and completion status.
- Sits between the harness loader (memory-image writer) and the DUT input ports.

Parameters:
DATA_W, 31, width of the `datai` field per entry
DEPTH, 51, number of table entries
ADDR_W, $clog2(DEPTH), entry index width
HOLD_W, 8, width of the per-entry hold field
WORD_W, 1+HOLD_W+DATA_W, stored word layout {obs, hold, data}, obs in the MSB

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
wr_en  in  1  table write strobe
wr_addr  in  ADDR_W  table write index
wr_word  in  WORD_W  table write data
start  in  1  begin playback (level sampled each edge)
stop  in  1  abort playback
loop_mode  in  1  0 = one-shot, 1 = wrap to entry 0 after end_addr
end_addr  in  ADDR_W  last entry played (inclusive), latched at start
datai  out  DATA_W  presented data vector
obs  out  1  presented observation bit
valid  out  1  datai/obs carry a live entry this cycle
pc  out  ADDR_W  index of the entry currently presented
busy  out  1  playback in progress
done  out  1  one-cycle pulse at one-shot completion
wrap_count  out  16  completed loop passes, saturating

Behaviour:
- The clock port is `clock` and the reset port is `reset`; reset is synchronous and active-high.
- Reset values: datai=0, obs=0, valid=0, pc=0, busy=0, done=0, wrap_count=0, state=IDLE. Table contents are NOT reset.
- Table:
  - Register array with a combinational read port.
  - A write occurs at the edge where wr_en=1 and state=IDLE.
  - wr_en while busy is ignored.
  - wr_addr >= DEPTH is ignored.
- States: IDLE, PLAY.
- Start, IDLE→PLAY:
  - Triggered at an edge with start=1, stop=0, wr_en=0.
  - Same edge: latch end_eff = min(end_addr, DEPTH-1) and loop_mode; clear wrap_count.
  - Load outputs from entry 0: datai, obs, hold_cnt = entry.hold; valid=1, busy=1, pc=0.
  - Latency start→first vector: 1 cycle.
- start with wr_en=1 in IDLE: start is ignored and the write completes.
- start in PLAY: ignored.
- PLAY, each edge:
  - If stop=1 → IDLE: valid=0, busy=0, no done. datai/obs hold their last values.
  - Else if hold_cnt != 0: hold_cnt decrements; outputs unchanged. Each entry is presented for hold+1 cycles.
  - Else if pc != end_eff: pc+1; load the next entry's fields; no bubble.
  - Else if loop_mode=1: pc=0; load entry 0; wrap_count+1, saturating at 16'hFFFF.
  - Else (one-shot end): → IDLE, valid=0, busy=0, done=1 for exactly one cycle. datai/obs/pc retain their last values.
- done is 0 in every cycle other than that single pulse.
- stop in IDLE: no effect. start+stop on the same edge in IDLE: stop wins, stays IDLE.
- Reset at any point, including mid-PLAY, returns all outputs to reset values on that edge. A later start replays from entry 0 with the table intact.
- No arithmetic overflow on pc: it only increments while pc < end_eff <= DEPTH-1.

Decomposition:
- Package conc_stim_pkg contains:
  - state enum {IDLE, PLAY};
  - field offset/width localparams for the obs/hold/data slices;
  - a function to pack a word from (obs, hold, data), also used by benches.
- One sub-module, conc_stim_mem: DEPTH×WORD_W array with a gated write port and a combinational read port.
- Sequencing FSM, hold counter, pc and status logic live in conc_stim_player.

Test Plan:
1. Load {0,0,1},{1,0,2},{0,0,3}; end_addr=2; loop_mode=0; start at edge N → edges N+1..N+3 show datai=1,2,3, obs=0,1,0, valid=1, pc=0,1,2. At N+4: valid=0, busy=0, done=1 for 1 cycle, datai stays 3.
2. Entry0 {0,2,5}, entry1 {1,0,9}, end_addr=1 → datai=5 with valid=1 for 3 cycles, then datai=9 with obs=1 for 1 cycle, then done.
3. loop_mode=1, end_addr=1, entries A=0x11, B=0x22 → A,B,A,B…, wrap_count=1 at the first return to A, 2 at the second. stop asserted → next edge valid=0, busy=0, done stays 0.
4. During PLAY: pulse start and write entry0=0x7F → playback unaffected. A later replay still presents the original entry 0.
5. Reset asserted while pc=1 → next edge all outputs 0. Deassert, start → entry 0 presented with preserved contents.
6. DEPTH=51, end_addr=63, one-shot → pc advances to 50, then done. Separately, end_addr=0, hold=0 → exactly one valid cycle, then done. start+stop same edge in IDLE → stays IDLE.

Source files
------------

// File: rtl/conc_stim_pkg.sv
// Shared types, default sizes, word-layout offsets and the word packer
// for the concolic stimulus player.
package conc_stim_pkg;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  localparam int unsigned DEF_DATA_W = 31;
  localparam int unsigned DEF_HOLD_W = 8;
  localparam int unsigned DEF_DEPTH  = 51;
  localparam int unsigned DEF_WORD_W = 1 + DEF_HOLD_W + DEF_DATA_W;

  // Stored word layout is {obs, hold, data}, with obs in the MSB.
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned HOLD_LSB = DEF_DATA_W;
  localparam int unsigned OBS_BIT  = DEF_DATA_W + DEF_HOLD_W;

  function automatic logic [DEF_WORD_W-1:0] pack_word(
    input logic                  obs,
    input logic [DEF_HOLD_W-1:0] hold,
    input logic [DEF_DATA_W-1:0] data
  );
    return {obs, hold, data};
  endfunction

endpackage

// File: rtl/conc_stim_mem.sv
// Vector table: register array with a gated write port and a
// combinational read port. Writes to indices past the end are dropped.
module conc_stim_mem #(
  parameter int unsigned WORD_W = 40,
  parameter int unsigned DEPTH  = 51,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_word,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_word_c
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_word;
  end

  assign rd_word_c = mem[rd_addr];

endmodule

// File: rtl/conc_stim_player.sv
// Stimulus replay engine: plays a preloaded vector table into a DUT,
// one-shot or looping, with per-entry hold counts and completion status.
module conc_stim_player
  import conc_stim_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned HOLD_W = DEF_HOLD_W,
  parameter int unsigned WORD_W = 1 + HOLD_W + DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [DATA_W-1:0] datai,
  output logic              obs,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [15:0]       wrap_count
);

  localparam int unsigned H_LSB = DATA_W;
  localparam int unsigned O_BIT = DATA_W + HOLD_W;

  state_t             state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [ADDR_W-1:0]  end_eff;
  logic               loop_q;
  logic [ADDR_W-1:0]  rd_addr_c;
  logic [WORD_W-1:0]  rd_word_c;
  logic [ADDR_W-1:0]  end_clip_c;
  logic               wr_gate_c;

  // Only advancing within a pass needs a non-zero read index; start and wrap read entry 0.
  assign rd_addr_c  = (state == PLAY && pc != end_eff) ? ADDR_W'(pc + ADDR_W'(1)) : '0;
  assign end_clip_c = (32'(end_addr) > DEPTH - 1) ? ADDR_W'(DEPTH - 1) : end_addr;
  assign wr_gate_c  = wr_en && (state == IDLE);

  conc_stim_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock     (clock),
    .wr_en     (wr_gate_c),
    .wr_addr   (wr_addr),
    .wr_word   (wr_word),
    .rd_addr   (rd_addr_c),
    .rd_word_c (rd_word_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      datai      <= '0;
      obs        <= 1'b0;
      valid      <= 1'b0;
      pc         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wrap_count <= '0;
      hold_cnt   <= '0;
      end_eff    <= '0;
      loop_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop && !wr_en) begin
            state      <= PLAY;
            end_eff    <= end_clip_c;
            loop_q     <= loop_mode;
            wrap_count <= '0;
            datai      <= rd_word_c[DATA_W-1:0];
            obs        <= rd_word_c[O_BIT];
            hold_cnt   <= rd_word_c[H_LSB +: HOLD_W];
            valid      <= 1'b1;
            busy       <= 1'b1;
            pc         <= '0;
          end
        end
        PLAY: begin
          if (stop) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else if (pc != end_eff) begin
            pc       <= ADDR_W'(pc + ADDR_W'(1));
            datai    <= rd_word_c[DATA_W-1:0];
            obs      <= rd_word_c[O_BIT];
            hold_cnt <= rd_word_c[H_LSB +: HOLD_W];
          end else if (loop_q) begin
            pc       <= '0;
            datai    <= rd_word_c[DATA_W-1:0];
            obs      <= rd_word_c[O_BIT];
            hold_cnt <= rd_word_c[H_LSB +: HOLD_W];
            if (wrap_count != 16'hFFFF) wrap_count <= wrap_count + 16'd1;
          end else begin
            // One-shot end: presented data and pc stay on the last entry.
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conc_stim_player.sv
// Directed bench for conc_stim_player: vector table plus hand sequences
// for looping, write-during-play, reset mid-play and table-end clipping.
module tb_conc_stim_player;
  import conc_stim_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [39:0] wr_word;
  logic        start;
  logic        stop;
  logic        loop_mode;
  logic [5:0]  end_addr;
  logic [30:0] datai;
  logic        obs;
  logic        valid;
  logic [5:0]  pc;
  logic        busy;
  logic        done;
  logic [15:0] wrap_count;

  int n_checks = 0;
  int n_fail   = 0;

  conc_stim_player dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_word    (wr_word),
    .start      (start),
    .stop       (stop),
    .loop_mode  (loop_mode),
    .end_addr   (end_addr),
    .datai      (datai),
    .obs        (obs),
    .valid      (valid),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .wrap_count (wrap_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        s, st, w, lm;
    logic [5:0]  a, ea;
    logic [39:0] wd;
    logic        v, o, b, d;
    logic [30:0] dat;
    logic [5:0]  p;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(input logic s, st, w, lm, input logic [5:0] a, ea,
                              input logic [39:0] wd, input logic v, o, b, d,
                              input logic [30:0] dat, input logic [5:0] p);
    vec_t r;
    r.s = s; r.st = st; r.w = w; r.lm = lm; r.a = a; r.ea = ea; r.wd = wd;
    r.v = v; r.o = o; r.b = b; r.d = d; r.dat = dat; r.p = p;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, o, b, d,
                         input logic [30:0] dat, input logic [5:0] p, input logic [15:0] wc);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".obs"},   32'(obs),   32'(o));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".datai"}, 32'(datai), 32'(dat));
    chk({tag, ".pc"},    32'(pc),    32'(p));
    chk({tag, ".wrap"},  32'(wrap_count), 32'(wc));
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    wr_en = 0; start = 0; stop = 0; reset = 0;
  endtask

  task automatic load(input logic [5:0] a, input logic o, input logic [7:0] h, input logic [30:0] d);
    idle_in();
    wr_en = 1; wr_addr = a; wr_word = pack_word(o, h, d);
    cyc();
    wr_en = 0;
  endtask

  initial begin
    reset = 1; wr_en = 0; wr_addr = 0; wr_word = 0; start = 0; stop = 0;
    loop_mode = 0; end_addr = 0;
    cyc(); cyc();
    chk_all("reset", 0, 0, 0, 0, 31'd0, 6'd0, 16'd0);
    reset = 0;

    //           s  st w  lm a   ea  word                    v  o  b  d  dat  pc
    tv[0]  = mk(0, 0, 1, 0, 0,  2, pack_word(0, 0, 1),    0, 0, 0, 0, 0,   0);
    tv[1]  = mk(0, 0, 1, 0, 1,  2, pack_word(1, 0, 2),    0, 0, 0, 0, 0,   0);
    tv[2]  = mk(0, 0, 1, 0, 2,  2, pack_word(0, 0, 3),    0, 0, 0, 0, 0,   0);
    tv[3]  = mk(1, 0, 1, 0, 3,  2, pack_word(0, 0, 31'h44), 0, 0, 0, 0, 0, 0);
    tv[4]  = mk(1, 1, 0, 0, 0,  2, 40'd0,                 0, 0, 0, 0, 0,   0);
    tv[5]  = mk(1, 0, 0, 0, 0,  2, 40'd0,                 1, 0, 1, 0, 1,   0);
    tv[6]  = mk(0, 0, 0, 0, 0,  2, 40'd0,                 1, 1, 1, 0, 2,   1);
    tv[7]  = mk(0, 0, 0, 0, 0,  2, 40'd0,                 1, 0, 1, 0, 3,   2);
    tv[8]  = mk(0, 0, 0, 0, 0,  2, 40'd0,                 0, 0, 0, 1, 3,   2);
    tv[9]  = mk(0, 0, 0, 0, 0,  2, 40'd0,                 0, 0, 0, 0, 3,   2);
    tv[10] = mk(0, 0, 1, 0, 0,  1, pack_word(0, 2, 5),    0, 0, 0, 0, 3,   2);
    tv[11] = mk(0, 0, 1, 0, 1,  1, pack_word(1, 0, 9),    0, 0, 0, 0, 3,   2);
    tv[12] = mk(1, 0, 0, 0, 0,  1, 40'd0,                 1, 0, 1, 0, 5,   0);
    tv[13] = mk(0, 0, 0, 0, 0,  1, 40'd0,                 1, 0, 1, 0, 5,   0);
    tv[14] = mk(0, 0, 0, 0, 0,  1, 40'd0,                 1, 0, 1, 0, 5,   0);
    tv[15] = mk(0, 0, 0, 0, 0,  1, 40'd0,                 1, 1, 1, 0, 9,   1);
    tv[16] = mk(0, 0, 0, 0, 0,  1, 40'd0,                 0, 1, 0, 1, 9,   1);
    tv[17] = mk(0, 0, 0, 0, 0,  1, 40'd0,                 0, 1, 0, 0, 9,   1);

    for (int i = 0; i < 18; i++) begin
      start = tv[i].s; stop = tv[i].st; wr_en = tv[i].w; loop_mode = tv[i].lm;
      wr_addr = tv[i].a; end_addr = tv[i].ea; wr_word = tv[i].wd;
      cyc();
      chk_all($sformatf("vec%0d", i), tv[i].v, tv[i].o, tv[i].b, tv[i].d, tv[i].dat, tv[i].p, 16'd0);
    end
    idle_in();

    // Looping playback with wrap counting, then stop.
    load(0, 0, 0, 31'h11);
    load(1, 0, 0, 31'h22);
    loop_mode = 1; end_addr = 1; start = 1;
    cyc(); start = 0;
    chk_all("loop0", 1, 0, 1, 0, 31'h11, 0, 16'd0);
    cyc(); chk_all("loop1", 1, 0, 1, 0, 31'h22, 1, 16'd0);
    cyc(); chk_all("loop2", 1, 0, 1, 0, 31'h11, 0, 16'd1);
    cyc(); chk_all("loop3", 1, 0, 1, 0, 31'h22, 1, 16'd1);
    cyc(); chk_all("loop4", 1, 0, 1, 0, 31'h11, 0, 16'd2);
    stop = 1;
    cyc(); stop = 0;
    chk_all("loopstop", 0, 0, 0, 0, 31'h11, 0, 16'd2);
    cyc(); chk("loopstop.done_after", 32'(done), 32'd0);

    // Start pulse and table write during play are ignored.
    loop_mode = 0; end_addr = 1; start = 1;
    cyc(); start = 0;
    chk_all("wplay0", 1, 0, 1, 0, 31'h11, 0, 16'd0);
    start = 1; wr_en = 1; wr_addr = 0; wr_word = pack_word(0, 0, 31'h7F);
    cyc(); idle_in();
    chk_all("wplay1", 1, 0, 1, 0, 31'h22, 1, 16'd0);
    cyc(); chk_all("wplay_done", 0, 0, 0, 1, 31'h22, 1, 16'd0);
    start = 1;
    cyc(); start = 0;
    chk_all("replay0", 1, 0, 1, 0, 31'h11, 0, 16'd0);
    cyc(); cyc();
    chk("replay.done", 32'(done), 32'd1);

    // Reset mid-play clears outputs but keeps the table.
    loop_mode = 1; end_addr = 1; start = 1;
    cyc(); start = 0;
    cyc(); chk("rst.pre_pc", 32'(pc), 32'd1);
    reset = 1;
    cyc(); reset = 0;
    chk_all("rst", 0, 0, 0, 0, 31'd0, 0, 16'd0);
    loop_mode = 0; start = 1;
    cyc(); start = 0;
    chk_all("rst_replay", 1, 0, 1, 0, 31'h11, 0, 16'd0);
    stop = 1; cyc(); stop = 0;

    // end_addr beyond the table clips to the last entry.
    for (int i = 0; i < 51; i++) load(6'(i), 1'(i % 2), 8'd0, 31'(i + 100));
    loop_mode = 0; end_addr = 6'd63; start = 1;
    for (int i = 0; i < 51; i++) begin
      cyc(); start = 0;
      if (i == 0 || i == 25 || i == 50)
        chk_all($sformatf("clip%0d", i), 1, 1'(i % 2), 1, 0, 31'(i + 100), 6'(i), 16'd0);
      else
        chk($sformatf("clip%0d.pc", i), 32'(pc), 32'(i));
    end
    cyc(); chk_all("clip_done", 0, 0, 0, 1, 31'd150, 6'd50, 16'd0);

    // Single-entry one-shot.
    end_addr = 0; start = 1;
    cyc(); start = 0;
    chk_all("single0", 1, 0, 1, 0, 31'd100, 0, 16'd0);
    cyc(); chk_all("single_done", 0, 0, 0, 1, 31'd100, 0, 16'd0);

    // start and stop together in IDLE: stays idle.
    start = 1; stop = 1;
    cyc(); idle_in();
    chk_all("startstop", 0, 0, 0, 0, 31'd100, 0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
